// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encoding and default width.
package div_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Controller states of the iterative divider.
  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_PREP = 2'd1,
    DIV_ST_ITER = 2'd2,
    DIV_ST_FIX  = 2'd3
  } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
// Ports:
//   rem_i     - current partial remainder (WIDTH+1 bits)
//   msb_i     - next dividend bit shifted into the remainder
//   divisor_i - divisor magnitude
//   rem_o     - next partial remainder
//   q_bit_o   - quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  localparam int unsigned EXT_W = WIDTH + 2;

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] diff;

  // Shift in the next dividend bit, then trial-subtract the divisor.
  always_comb begin
    shifted = {rem_i, msb_i};
    diff    = shifted - EXT_W'(divisor_i);
    // Partial remainder stays below the divisor, so shifted[WIDTH+1] is
    // normally zero and diff's top bit is the borrow.
    q_bit_o = shifted[EXT_W-1] | ~diff[EXT_W-1];
    rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule : div_step

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with flush.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start, is_signed - request and signedness, sampled in IDLE with a, b
//   a, b             - dividend, divisor
//   flush            - abort any in-flight operation, results untouched
//   busy             - operation in progress
//   done             - one-cycle pulse, results valid
//   quotient         - registered quotient, held until next done
//   remainder        - registered remainder, held until next done
//   div_zero         - registered divide-by-zero flag, updated with done
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned REM_W = WIDTH + 1;

  div_state_e       state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dzo_q, dzo_d;

  logic [REM_W-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .msb_i    (dvd_q[WIDTH-1]),
    .divisor_i(dsr_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dzo_q   <= dzo_d;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dzo_d   = dzo_q;

    unique case (state_q)
      DIV_ST_IDLE: begin
        if (start && !flush) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          state_d = DIV_ST_PREP;
        end
      end

      DIV_ST_PREP: begin
        q_neg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg_d = sgn_q & a_q[WIDTH-1];
        dvd_d   = (sgn_q & a_q[WIDTH-1]) ? -a_q : a_q;
        dsr_d   = (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
        rem_d   = '0;
        cnt_d   = '0;
        if (b_q == '0) begin
          dz_d    = 1'b1;
          state_d = DIV_ST_FIX;
        end else begin
          dz_d    = 1'b0;
          state_d = DIV_ST_ITER;
        end
      end

      DIV_ST_ITER: begin
        // Dividend register doubles as the quotient shift register.
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DIV_ST_FIX: begin
        state_d = DIV_ST_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          quo_d = '1;
          rmd_d = a_q;
          dzo_d = 1'b1;
        end else begin
          quo_d = q_neg_q ? -dvd_q : dvd_q;
          rmd_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dzo_d = 1'b0;
        end
      end

      default: state_d = DIV_ST_IDLE;
    endcase

    // Squash: abandon the operation and leave the visible results alone.
    if (flush && (state_q != DIV_ST_IDLE)) begin
      state_d = DIV_ST_IDLE;
      done_d  = 1'b0;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dzo_d   = dzo_q;
    end

    busy_d = (state_d != DIV_ST_IDLE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dzo_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total;
  int bad;

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, scramble the operand inputs afterwards, and wait
  // (bounded) for done. edges counts edges after the accepting edge.
  task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        output int edges, output int busy_n, output int overlap);
    is_signed = sgn;
    a         = av;
    b         = bv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    a         = 32'hDEAD_BEEF;
    b         = 32'h0000_0003;
    is_signed = ~sgn;
    edges     = 0;
    busy_n    = busy ? 1 : 0;
    overlap   = 0;
    while (!done && edges < 100) begin
      tick();
      edges++;
      if (busy) busy_n++;
      if (busy && done) overlap++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_q: got %h want 0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL reset_r: got %h want 0", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int e, bn, ov;
    run_op(1'b0, 32'd100, 32'd7, e, bn, ov);
    total++; if (e !== 34) begin bad++; $display("FAIL unsigned_latency: got %0d want 34", e); end
    total++; if (bn !== 34) begin bad++; $display("FAIL unsigned_busy_cycles: got %0d want 34", bn); end
    total++; if (ov !== 0) begin bad++; $display("FAIL unsigned_busy_done_overlap: got %0d want 0", ov); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL unsigned_q: got %h want %h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL unsigned_r: got %h want %h", remainder, 32'd2); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL unsigned_dz: got %b want 0", div_zero); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL q_hold: got %h want %h", quotient, 32'd14); end
  endtask

  task automatic test_signed();
    int e, bn, ov;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, e, bn, ov);
    total++; if (e !== 34) begin bad++; $display("FAIL signed_latency: got %0d want 34", e); end
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL signed_q: got %h want FFFFFFFD", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL signed_r: got %h want FFFFFFFF", remainder); end
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, e, bn, ov);
    total++; if (quotient !== 32'h7FFF_FFFC) begin bad++; $display("FAIL unsigned_neg7_q: got %h want 7FFFFFFC", quotient); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL unsigned_neg7_r: got %h want 1", remainder); end
  endtask

  task automatic test_overflow();
    int e, bn, ov;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, bn, ov);
    total++; if (e !== 34) begin bad++; $display("FAIL ovf_latency: got %0d want 34", e); end
    total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL ovf_q: got %h want 80000000", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL ovf_r: got %h want 0", remainder); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, e, bn, ov);
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL max_div1_q: got %h want FFFFFFFF", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL max_div1_r: got %h want 0", remainder); end
  endtask

  task automatic test_div_zero();
    int e, bn, ov;
    run_op(1'b0, 32'h0000_1234, 32'h0, e, bn, ov);
    total++; if (e !== 2) begin bad++; $display("FAIL dz_latency: got %0d want 2", e); end
    total++; if (bn !== 2) begin bad++; $display("FAIL dz_busy_cycles: got %0d want 2", bn); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_q: got %h want FFFFFFFF", quotient); end
    total++; if (remainder !== 32'h0000_1234) begin bad++; $display("FAIL dz_r: got %h want 00001234", remainder); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    run_op(1'b0, 32'd100, 32'd7, e, bn, ov);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL dz_next_q: got %h want %h", quotient, 32'd14); end
  endtask

  task automatic test_flush();
    int e, bn, ov, dn;
    run_op(1'b0, 32'd1000, 32'd3, e, bn, ov);
    total++; if (quotient !== 32'd333) begin bad++; $display("FAIL pre_flush_q: got %h want %h", quotient, 32'd333); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL pre_flush_r: got %h want 1", remainder); end
    // start together with flush in IDLE is dropped
    is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_drop: busy got %b want 0", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_idle: busy got %b want 0", busy); end
    // flush during the 10th ITER cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_mid_busy: got %b want 1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      tick();
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL flush_no_done: got %0d done pulses want 0", dn); end
    total++; if (quotient !== 32'd333) begin bad++; $display("FAIL flush_q_kept: got %h want %h", quotient, 32'd333); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL flush_r_kept: got %h want 1", remainder); end
    run_op(1'b0, 32'd100, 32'd7, e, bn, ov);
    total++; if (e !== 34) begin bad++; $display("FAIL post_flush_latency: got %0d want 34", e); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL post_flush_q: got %h want %h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL post_flush_r: got %h want 2", remainder); end
  endtask

  task automatic test_back_to_back();
    int e;
    is_signed = 1'b0; a = 32'd50; b = 32'd5; start = 1'b1;
    tick();
    // start stays high; new operands must not disturb the running divide
    a = 32'd77; b = 32'd4;
    e = 0;
    while (!done && e < 100) begin tick(); e++; end
    total++; if (e !== 34) begin bad++; $display("FAIL b2b_first_latency: got %0d want 34", e); end
    total++; if (quotient !== 32'd10) begin bad++; $display("FAIL b2b_first_q: got %h want %h", quotient, 32'd10); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL b2b_first_r: got %h want 0", remainder); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept: busy got %b want 1", busy); end
    start = 1'b0;
    e = 0;
    while (!done && e < 100) begin tick(); e++; end
    total++; if (e !== 34) begin bad++; $display("FAIL b2b_second_latency: got %0d want 34", e); end
    total++; if (quotient !== 32'd19) begin bad++; $display("FAIL b2b_second_q: got %h want %h", quotient, 32'd19); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL b2b_second_r: got %h want 1", remainder); end
  endtask

  task automatic test_rst_mid();
    int e, bn, ov;
    is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL rst_mid_q: got %h want 0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL rst_mid_r: got %h want 0", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL rst_mid_dz: got %b want 0", div_zero); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: busy got %b want 0", busy); end
    run_op(1'b0, 32'd100, 32'd7, e, bn, ov);
    total++; if (e !== 34) begin bad++; $display("FAIL post_rst_latency: got %0d want 34", e); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL post_rst_q: got %h want %h", quotient, 32'd14); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = 32'h0;
    b         = 32'h0;
    flush     = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_seq
